// File: rtl/mvu_job_watchdog_if.sv
// rtl/mvu_job_watchdog_if.sv - job start/done, control and status bundle for the MVU job watchdog
interface mvu_job_watchdog_if #(
  parameter int N     = 8,
  parameter int CNT_W = 24,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]     chan_en;
  logic [N-1:0]     start;
  logic [N-1:0]     done;
  logic [CNT_W-1:0] timeout_cycles;
  logic             clear;
  logic [N-1:0]     busy;
  logic [N-1:0]     timed_out;
  logic [N-1:0]     proto_err;
  logic             all_done;
  logic             any_timeout;
  logic [SEL_W-1:0] rd_sel;
  logic [CNT_W-1:0] rd_lat;
  logic             rd_valid;

  // Side that issues jobs and reads back status (bench / MVU driver)
  modport master (
    output chan_en, start, done, timeout_cycles, clear, rd_sel,
    input  busy, timed_out, proto_err, all_done, any_timeout, rd_lat, rd_valid
  );

  // Watchdog side
  modport slave (
    input  chan_en, start, done, timeout_cycles, clear, rd_sel,
    output busy, timed_out, proto_err, all_done, any_timeout, rd_lat, rd_valid
  );
endinterface

// File: rtl/mvu_job_watchdog.sv
// rtl/mvu_job_watchdog.sv - per-channel MVU job latency monitor, timeout and protocol checker
module mvu_job_watchdog #(
  parameter int N     = 8,
  parameter int CNT_W = 24,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mvu_job_watchdog_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state [N];
  logic [CNT_W-1:0] cnt   [N];
  logic [CNT_W-1:0] lat   [N];
  logic [N-1:0]     perr;

  logic [N-1:0]     busy_q;
  logic [N-1:0]     to_q;
  logic [N-1:0]     perr_q;
  logic [N-1:0]     done_q;
  logic             all_done_q;
  logic             any_timeout_q;
  logic [CNT_W-1:0] rd_lat_q;
  logic             rd_valid_q;
  logic             sel_ok;

  // Equality compare means a budget lowered below the running count never fires.
  logic             to_en;
  assign to_en  = (bus.timeout_cycles != '0);
  assign sel_ok = ({{(32-SEL_W){1'b0}}, bus.rd_sel} < 32'(N));

  // Per-channel job FSM: latency counter, latched latency and sticky protocol error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state[i] <= ST_IDLE;
        cnt[i]   <= '0;
        lat[i]   <= '0;
      end
      perr <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < N; i++) begin
        state[i] <= ST_IDLE;
        cnt[i]   <= '0;
        lat[i]   <= '0;
      end
      perr <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        case (state[i])
          ST_BUSY: begin
            // A start while running is always a violation; done still wins over timeout.
            if (bus.start[i]) perr[i] <= 1'b1;
            if (bus.done[i]) begin
              state[i] <= ST_DONE;
              lat[i]   <= cnt[i];
            end else if (to_en && (cnt[i] == bus.timeout_cycles)) begin
              state[i] <= ST_TIMEOUT;
              lat[i]   <= cnt[i];
            end else if (cnt[i] != CNT_MAX) begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          default: begin
            // IDLE, DONE and TIMEOUT all accept a new job; a done here is orphaned.
            if (bus.start[i]) begin
              state[i] <= ST_BUSY;
              cnt[i]   <= CNT_ONE;
            end
            if (bus.done[i]) perr[i] <= 1'b1;
          end
        endcase
      end
    end
  end

  // Registered per-channel status decodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      to_q   <= '0;
      done_q <= '0;
      perr_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        busy_q[i] <= (state[i] == ST_BUSY);
        to_q[i]   <= (state[i] == ST_TIMEOUT);
        done_q[i] <= (state[i] == ST_DONE);
      end
      perr_q <= perr;
    end
  end

  // Aggregate flags, one register behind the per-channel decodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_done_q    <= 1'b0;
      any_timeout_q <= 1'b0;
    end else begin
      all_done_q    <= (bus.chan_en != '0) && ((done_q | ~bus.chan_en) == {N{1'b1}});
      any_timeout_q <= |to_q;
    end
  end

  // Latency readout mux; out-of-range selects read as empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_lat_q   <= '0;
      rd_valid_q <= 1'b0;
    end else if (sel_ok) begin
      rd_lat_q   <= lat[bus.rd_sel];
      rd_valid_q <= (state[bus.rd_sel] == ST_DONE);
    end else begin
      rd_lat_q   <= '0;
      rd_valid_q <= 1'b0;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.timed_out   = to_q;
  assign bus.proto_err   = perr_q;
  assign bus.all_done    = all_done_q;
  assign bus.any_timeout = any_timeout_q;
  assign bus.rd_lat      = rd_lat_q;
  assign bus.rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_mvu_job_watchdog.sv
// tb/tb_mvu_job_watchdog.sv - randomized self-checking bench for mvu_job_watchdog
module tb_mvu_job_watchdog;
  localparam int N     = 5;
  localparam int CNT_W = 5;
  localparam int SEL_W = 3;
  localparam int MAXC  = (1 << CNT_W) - 1;

  localparam int P_IDLE = 0;
  localparam int P_BUSY = 1;
  localparam int P_DONE = 2;
  localparam int P_TO   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mvu_job_watchdog_if #(.N(N), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

  mvu_job_watchdog #(.N(N), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: job phase, start timestamp, latched latency, sticky error per channel,
  // plus the two previous post-edge snapshots the registered outputs are built from.
  int m_ph [N];
  int m_t0 [N];
  int m_lat[N];
  bit m_err[N];
  int h1_ph [N];
  int h1_lat[N];
  bit h1_err[N];
  int h2_ph [N];
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_ph[i] = P_IDLE; m_t0[i] = 0; m_lat[i] = 0; m_err[i] = 1'b0;
      h1_ph[i] = P_IDLE; h1_lat[i] = 0; h1_err[i] = 1'b0; h2_ph[i] = P_IDLE;
    end
  endtask

  // Apply the job rules for the edge just taken, using inputs held across it.
  task automatic model_edge();
    int el;
    int tc;
    cyc++;
    tc = int'(bus.timeout_cycles);
    for (int i = 0; i < N; i++) begin
      h2_ph[i]  = h1_ph[i];
      h1_ph[i]  = m_ph[i];
      h1_lat[i] = m_lat[i];
      h1_err[i] = m_err[i];
    end
    for (int i = 0; i < N; i++) begin
      if (bus.clear) begin
        m_ph[i] = P_IDLE; m_lat[i] = 0; m_err[i] = 1'b0;
      end else if (m_ph[i] == P_BUSY) begin
        el = cyc - m_t0[i];
        if (el > MAXC) el = MAXC;
        if (bus.start[i]) m_err[i] = 1'b1;
        if (bus.done[i]) begin
          m_ph[i] = P_DONE; m_lat[i] = el;
        end else if (tc != 0 && el == tc) begin
          m_ph[i] = P_TO; m_lat[i] = el;
        end
      end else begin
        if (bus.start[i]) begin
          m_ph[i] = P_BUSY; m_t0[i] = cyc;
        end
        if (bus.done[i]) m_err[i] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eb, et, ep;
    logic ead, eat;
    logic [31:0] erl;
    logic erv;
    int sel;
    eb = '0; et = '0; ep = '0; eat = 1'b0;
    ead = (bus.chan_en != '0);
    for (int i = 0; i < N; i++) begin
      eb[i] = (h1_ph[i] == P_BUSY);
      et[i] = (h1_ph[i] == P_TO);
      ep[i] = h1_err[i];
      if (h2_ph[i] == P_TO) eat = 1'b1;
      if (bus.chan_en[i] && h2_ph[i] != P_DONE) ead = 1'b0;
    end
    sel = int'(bus.rd_sel);
    erl = (sel < N) ? 32'(h1_lat[sel]) : 32'd0;
    erv = (sel < N) ? (h1_ph[sel] == P_DONE) : 1'b0;
    check("busy",        32'(bus.busy),        32'(eb));
    check("timed_out",   32'(bus.timed_out),   32'(et));
    check("proto_err",   32'(bus.proto_err),   32'(ep));
    check("all_done",    32'(bus.all_done),    32'(ead));
    check("any_timeout", 32'(bus.any_timeout), 32'(eat));
    check("rd_lat",      32'(bus.rd_lat),      erl);
    check("rd_valid",    32'(bus.rd_valid),    32'(erv));
  endtask

  // Called at a negedge: drive pulses, take one edge, check at the next negedge.
  task automatic step(input logic [N-1:0] s, input logic [N-1:0] d, input logic clr);
    bus.start = s;
    bus.done  = d;
    bus.clear = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0);
  endtask

  initial begin
    logic [N-1:0] rs, rd;
    bus.chan_en = '1;
    bus.start = '0;
    bus.done = '0;
    bus.timeout_cycles = '0;
    bus.clear = 1'b0;
    bus.rd_sel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Completed job: lat 25 readable, no error
    bus.timeout_cycles = 5'd30;
    step(5'b00001, '0, 1'b0);
    idle(24);
    step('0, 5'b00001, 1'b0);
    idle(1);
    check("dir_lat25", 32'(bus.rd_lat), 32'd25);
    check("dir_valid0", 32'(bus.rd_valid), 32'd1);
    check("dir_perr0", 32'(bus.proto_err[0]), 32'd0);

    // Hung job times out at budget 20
    bus.timeout_cycles = 5'd20;
    bus.rd_sel = 3'd1;
    step(5'b00010, '0, 1'b0);
    idle(21);
    check("dir_to1", 32'(bus.timed_out[1]), 32'd1);
    check("dir_tolat", 32'(bus.rd_lat), 32'd20);
    idle(1);
    check("dir_anyto", 32'(bus.any_timeout), 32'd1);

    // Done exactly at the budget edge beats the timeout
    step(5'b00100, '0, 1'b0);
    idle(19);
    bus.rd_sel = 3'd2;
    step('0, 5'b00100, 1'b0);
    idle(1);
    check("dir_edge_lat", 32'(bus.rd_lat), 32'd20);
    check("dir_edge_valid", 32'(bus.rd_valid), 32'd1);
    check("dir_edge_to", 32'(bus.timed_out[2]), 32'd0);

    // all_done over enabled subset while ch1 hangs
    step('0, '0, 1'b1);
    bus.chan_en = 5'b00101;
    bus.timeout_cycles = '0;
    step(5'b00111, '0, 1'b0);
    idle(3);
    step('0, 5'b00001, 1'b0);
    step('0, 5'b00100, 1'b0);
    idle(2);
    check("dir_alldone", 32'(bus.all_done), 32'd1);
    bus.chan_en = '0;
    idle(2);
    check("dir_alldone_none", 32'(bus.all_done), 32'd0);
    bus.chan_en = '1;

    // Double start keeps the original count; orphan done; clear
    bus.rd_sel = 3'd3;
    step(5'b01000, '0, 1'b0);
    idle(5);
    step(5'b01000, '0, 1'b0);
    idle(3);
    step('0, 5'b01000, 1'b0);
    idle(1);
    check("dir_dbl_lat", 32'(bus.rd_lat), 32'd10);
    step('0, 5'b10000, 1'b0);
    idle(1);
    check("dir_perr34", 32'(bus.proto_err[4:3]), 32'd3);
    step('0, '0, 1'b1);
    idle(1);
    check("dir_clr_perr", 32'(bus.proto_err), 32'd0);
    check("dir_clr_busy", 32'(bus.busy), 32'd0);

    // Saturation with timeout disabled
    bus.rd_sel = 3'd0;
    step(5'b00001, '0, 1'b0);
    idle(40);
    step('0, 5'b00001, 1'b0);
    idle(1);
    check("dir_sat", 32'(bus.rd_lat), 32'(MAXC));

    // Asynchronous reset mid-job, then late dones are orphans
    step(5'b11111, '0, 1'b0);
    idle(5);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_perr", 32'(bus.proto_err), 32'd0);
    check("rst_lat", 32'(bus.rd_lat), 32'd0);
    check("rst_to", 32'(bus.timed_out), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step('0, 5'b11111, 1'b0);
    idle(1);
    check("rst_orphan", 32'(bus.proto_err), 32'h1f);
    check("rst_busy2", 32'(bus.busy), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 49) == 0) bus.chan_en = N'($urandom);
      if ($urandom_range(0, 39) == 0) bus.timeout_cycles = CNT_W'($urandom_range(0, MAXC));
      bus.rd_sel = SEL_W'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        rs[i] = ($urandom_range(0, 11) == 0);
        rd[i] = ($urandom_range(0, 9) == 0);
      end
      step(rs, rd, $urandom_range(0, 149) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mvu_job_watchdog.md
# mvu_job_watchdog

Parametrised, synthesizable job watchdog and latency monitor for multi-channel MVU simulation and FPGA bring-up. It tracks up to N concurrent MVU jobs, each bracketed by a start pulse and a done pulse. Per channel it measures the start-to-done latency in clock cycles, flags jobs that exceed a programmable cycle budget, and detects protocol violations. It replaces the bench's single global millisecond timeout with per-channel, cycle-accurate supervision and sits beside the MVU top, driven from the same interface signals.

## Interface
- N, 8: number of supervised channels (1..64)
- CNT_W, 24: width of latency counters and timeout budget
- SEL_W, $clog2(N) (min 1): width of readout select
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- chan_en  in  N  channel participates in all_done; disabled channels still monitored
- start  in  N  per-channel job-start pulse, sampled on rising clk
- done  in  N  per-channel job-done pulse, sampled on rising clk
- timeout_cycles  in  CNT_W  per-job budget; 0 disables timeout
- clear  in  1  synchronous clear of all channel state and flags
- busy  out  N  channel in BUSY
- timed_out  out  N  channel in TIMEOUT
- proto_err  out  N  sticky protocol-violation flag
- all_done  out  1  every enabled channel in DONE; 0 if chan_en == 0
- any_timeout  out  1  OR of timed_out
- rd_sel  in  SEL_W  latency readout channel select
- rd_lat  out  CNT_W  latched latency of channel rd_sel, registered
- rd_valid  out  1  selected channel has a latched latency (DONE)

## Operation
- Per-channel FSM, states IDLE, BUSY, DONE, TIMEOUT; reset state IDLE.
- IDLE / DONE / TIMEOUT + start → BUSY, cnt <= 1.
- BUSY + done → DONE, lat <= cnt.
- BUSY, no done, timeout_cycles != 0, cnt == timeout_cycles → TIMEOUT; lat <= cnt.
- BUSY otherwise: cnt <= cnt + 1, saturating at all-ones. Saturation never wraps.
- Same-cycle priority, highest first: clear, done, timeout.
- start while BUSY: ignored, proto_err set.
- done in IDLE, DONE or TIMEOUT: ignored, proto_err set.
- start and done together in BUSY: done taken, proto_err set.
- start and done together outside BUSY: start taken, proto_err set.
- clear: every channel → IDLE; cnt, lat, proto_err → 0.
- timeout_cycles is sampled every cycle, not latched at start. Lowering it below cnt never fires a timeout because the compare is equality; the job runs to done or saturation.
- Outputs busy, timed_out and proto_err are registered, direct decodes of state.
- all_done = (chan_en != 0) && for every i with chan_en[i], state[i] == DONE. Registered.
- rd_lat / rd_valid are registered from a mux of lat[rd_sel] and (state[rd_sel] == DONE). rd_sel >= N gives rd_lat = 0, rd_valid = 0.

## Timing
- Reset (rst_n low, async): all outputs 0, all FSMs IDLE, counters 0; deassertion is synchronous to clk by convention of the driver.
- Latency convention: start sampled at edge t, done sampled at edge t+k → lat = k. Minimum k = 1.
- Timeout fires at edge t+timeout_cycles when no done was sampled at that edge. timed_out is visible after that edge.
- Status flags are visible one cycle after the causing edge.
- all_done and any_timeout: one further register, 2 cycles after the causing edge.
- rd_lat: 1 cycle after rd_sel change or lat update.
- Back-to-back: done at edge e and start at edge e+1 is legal; done and start at the same edge is an error, per the rules above.
- Reset mid-job: channel returns to IDLE immediately; a done arriving afterwards sets proto_err.

## Test plan
- N=4, budget 100; start ch0 at edge 10, done at edge 47 → busy[0] 1 from edge 11, lat 37, rd_sel=0 gives rd_lat=37, rd_valid=1, proto_err 0.
- Budget 20, start ch1, no done → timed_out[1]=1 after edge start+20, any_timeout=1 two cycles later, lat 20. A done at budget edge instead → DONE, no timeout.
- chan_en=4'b0101, ch0 and ch2 complete while ch1 hangs → all_done=1; chan_en=0 → all_done=0.
- Double start on ch3 while BUSY → counter continues from original start, proto_err[3]=1. Orphan done on ch2 in IDLE → proto_err[2]=1. clear → all flags 0, all IDLE.
- CNT_W=4, budget 0, start with no done for 20 cycles → cnt saturates at 15, no timeout; done → lat 15.
- rst_n pulsed low mid-BUSY on all channels → all outputs 0 asynchronously; a subsequent done sets proto_err only.
